gray_conv_arbiter: RTL
======================

# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one bit-serial Gray-to-binary conversion engine among NREQ requesters, such as encoder-position channels. Each request is a WIDTH-bit Gray word. The block grants one requester at a time and converts the word MSB-first, one bit per cycle. It presents the binary result with the requester ID on a valid/ready output port. It sits between the Gray-coded sources and the consumer of the binary values.

## Interface
- WIDTH, 4: Gray/binary word width, at least 2.
- NREQ, 4: number of requesters, at least 2.
- IDW, $clog2(NREQ): width of out_id (derived; do not override).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_gray  in  NREQ*WIDTH  Gray words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept strobe.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_bin  out  WIDTH  converted binary word.
- out_id  out  IDW  index of the requester that produced out_bin.
- out_err  out  1  adjacency error flag for this result (see Configuration).
- busy  out  1  high in CONV or DONE.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - Pick the first i with req_valid[i]=1, searching from ptr upward with wrap-around.
  - Drive req_ready[i]=1 combinationally. req_ready depends only on state, ptr and req_valid, never on out_ready.
  - The transfer occurs when valid and ready are both high. Latch the word and the ID, then go to CONV.
  - If no request is valid, stay in IDLE with req_ready=0.
- CONV runs for WIDTH cycles, with bit counter k going from WIDTH-1 down to 0:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[k] = b[k+1] ^ g[k].
  - After bit 0, go to DONE.
- DONE:
  - out_valid=1. out_bin, out_id and out_err stay stable until out_ready=1.
  - On handshake: ptr <= (out_id+1) mod NREQ, go to IDLE.
- req_ready is 0 in CONV and DONE; only one word is in flight at a time.
- Requesters must hold req_valid and req_gray until granted. Arbitration is re-evaluated every IDLE cycle, so a withdrawn request is simply skipped.
- out_bin is the working register. Its value is meaningful only while out_valid=1.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, out_valid=0, out_bin=0, out_id=0, out_err=0, busy=0. Reset also clears all per-requester check state.
- Cycle T: accept (req_ready & req_valid). Cycles T+1..T+WIDTH: CONV. Cycle T+WIDTH+1: out_valid=1.
- If out_ready=1 in the first DONE cycle, the block is back in IDLE at T+WIDTH+2. The next grant can be in that cycle, giving throughput of one word per WIDTH+2 cycles.
- Backpressure: DONE is held for any number of cycles. No new grant is issued while out_valid=1.
- A requester granted at T is lowest priority at the next grant.
- Simultaneous requests: the ptr-ordered winner is served; the others wait and are not lost.
- rst in any state:
  - The next state is the reset state.
  - Any in-flight word is discarded and no out_valid is produced for it.
  - rst has priority over every handshake in the same cycle.

## Configuration
- GRAY_CONV_ADJ_CHECK_EN defined:
  - Per requester, keep the last accepted Gray word and a seen flag.
  - On acceptance, if seen=1 and popcount(prev ^ new) > 1, set out_err=1 for that result.
  - A difference of 0 or 1 bit is legal.
  - Update prev and set seen on every accepted word.
- Not defined: out_err is tied to 0 and no per-requester storage exists. The port list is unchanged.

## Test plan
- Single request, WIDTH=4: requester 0 with gray 4'b0011 accepted at T -> out_valid at T+5, out_bin=4'b0010, out_id=0. Repeat with 0100->0111, 1111->1010, 1010->1100, 1000->1111.
- Fairness: all four req_valid high after reset with gray 0010, 0111, 1010, 1000 -> results in order ids 0,1,2,3 with bins 0011, 0101, 1100, 1111. Each req_ready pulses exactly once.
- Backpressure: out_ready held 0 for 3 cycles in DONE -> out_valid, out_bin and out_id stable. req_ready all 0. Completion follows on the cycle out_ready rises.
- Reset mid-CONV: rst at T+2 -> out_valid never rises for that word, all outputs at reset values at T+3. A new request then converts normally with grant starting from ptr=0.
- Adjacency: requester 2 sends 0111 then 1010 -> second result out_err=1 with GRAY_CONV_ADJ_CHECK_EN, 0 without. Sequence 0111 then 0101 -> out_err=0 in both builds.
- Wrap-around: only requester 3 then requester 0 valid, starting from ptr=3 -> grants 3 then 0, ptr returns to 0 then 1.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one bit-serial Gray-to-binary engine among NREQ requesters.
// Optional per-requester adjacency checking is enabled with `define GRAY_CONV_ADJ_CHECK_EN.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  out_err,
  output logic                  busy
);

  localparam int KW = $clog2(WIDTH);
  localparam int CW = IDW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [KW-1:0]    bit_k;
  logic [WIDTH-1:0] gray_q;
  logic             acc_b;
  logic             conv_b;

  logic [WIDTH-1:0] req_word [NREQ];
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [CW-1:0]    cand;
  logic             accept;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_word[i] = req_gray[i*WIDTH +: WIDTH];
    end
  end

  // Rotating search: first valid requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int o = 0; o < NREQ; o++) begin
      cand = {1'b0, ptr} + CW'(o);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && grant_found;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign conv_b    = acc_b ^ gray_q[bit_k];
  assign ptr_nxt   = (out_id == IDW'(NREQ - 1)) ? '0 : out_id + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = CONV;
      CONV:    if (bit_k == '0)    state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // acc_b carries b[k+1]; it starts at 0 so the MSB comes out as g[WIDTH-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      out_bin <= '0;
      out_id  <= '0;
      gray_q  <= '0;
      bit_k   <= '0;
      acc_b   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gray_q <= req_word[grant_idx];
            out_id <= grant_idx;
            bit_k  <= KW'(WIDTH - 1);
            acc_b  <= 1'b0;
          end
        end
        CONV: begin
          out_bin[bit_k] <= conv_b;
          acc_b          <= conv_b;
          bit_k          <= bit_k - 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            ptr <= ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_CONV_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_gray [NREQ];
  logic [NREQ-1:0]  seen;
  logic             adj_err;
  logic             err_q;

  function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  assign adj_err = seen[grant_idx] &&
                   (popcount(prev_gray[grant_idx] ^ req_word[grant_idx]) > 1);

  always_ff @(posedge clk) begin
    // NOTE: the history array is reset deliberately; a stale seen flag would raise a false error after reset.
    if (rst) begin
      seen  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        prev_gray[i] <= '0;
      end
    end else if (accept) begin
      prev_gray[grant_idx] <= req_word[grant_idx];
      seen[grant_idx]      <= 1'b1;
      err_q                <= adj_err;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
